// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: owner encoding and the muxed memory access.
package dmem_arb_pkg;

    localparam int unsigned DMEM_AW = 32;
    localparam int unsigned DMEM_DW = 32;

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_CORE,
        OWN_EXT
    } owner_e;

    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } mem_req_t;

    function automatic owner_e other_owner(owner_e own);
        return (own == OWN_CORE) ? OWN_EXT : OWN_CORE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);

    logic          core_req_i;
    logic          core_we_i;
    logic [AW-1:0] core_addr_i;
    logic [DW-1:0] core_wdata_i;
    logic          core_gnt_o;
    logic [DW-1:0] core_rdata_o;
    logic          core_stall_o;

    logic          ext_req_i;
    logic          ext_we_i;
    logic [AW-1:0] ext_addr_i;
    logic [DW-1:0] ext_wdata_i;
    logic          ext_gnt_o;
    logic [DW-1:0] ext_rdata_o;

    logic          mem_we_o;
    logic          mem_cs_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i,
        input  mem_rdata_i,
        output core_gnt_o, core_rdata_o, core_stall_o,
        output ext_gnt_o, ext_rdata_o,
        output mem_we_o, mem_cs_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i,
        output mem_rdata_i,
        input  core_gnt_o, core_rdata_o, core_stall_o,
        input  ext_gnt_o, ext_rdata_o,
        input  mem_we_o, mem_cs_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dmem_arb_burst_cnt.sv
// Counts granted cycles of the current owner while the other side waits; flags the burst limit.
module dmem_arb_burst_cnt #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_o
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign limit_o = (cnt_q == CntW'(MAX_BURST - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !limit_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter between the core load/store path and an external port.
// Optional build macro DMEM_ARB_PARK_CORE_EN: core is granted with zero latency while idle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW        = DMEM_DW,
    parameter int unsigned AW        = DMEM_AW,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_PARK_CORE_EN
    localparam bit ParkCore = 1'b1;
`else
    localparam bit ParkCore = 1'b0;
`endif

    owner_e   owner_q, owner_d;
    owner_e   last_q, last_d;
    logic     burst_clr, burst_inc, burst_limit;
    logic     park_gnt, core_gnt, ext_gnt;
    logic     own_req, oth_req;
    mem_req_t core_acc, ext_acc, sel_acc;

    dmem_arb_burst_cnt #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (burst_clr),
        .inc_i   (burst_inc),
        .limit_o (burst_limit)
    );

    // Parked core only gets the idle memory when the external port is not also asking.
    assign park_gnt = ParkCore & (owner_q == OWN_IDLE) & bus.core_req_i & ~bus.ext_req_i;
    assign core_gnt = ~rst_i & (((owner_q == OWN_CORE) & bus.core_req_i) | park_gnt);
    assign ext_gnt  = ~rst_i & (owner_q == OWN_EXT) & bus.ext_req_i;

    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        burst_clr = 1'b0;
        burst_inc = 1'b0;
        own_req   = 1'b0;
        oth_req   = 1'b0;
        unique case (owner_q)
            OWN_IDLE: begin
                burst_clr = 1'b1;
                if (bus.core_req_i && bus.ext_req_i) begin
                    owner_d = (last_q == OWN_CORE) ? OWN_EXT : OWN_CORE;
                end else if (bus.ext_req_i) begin
                    owner_d = OWN_EXT;
                end else if (bus.core_req_i && !ParkCore) begin
                    owner_d = OWN_CORE;
                end
            end
            OWN_CORE, OWN_EXT: begin
                own_req = (owner_q == OWN_CORE) ? bus.core_req_i : bus.ext_req_i;
                oth_req = (owner_q == OWN_CORE) ? bus.ext_req_i : bus.core_req_i;
                if (!own_req) begin
                    owner_d = oth_req ? other_owner(owner_q) : OWN_IDLE;
                end else if (oth_req) begin
                    if (burst_limit) begin
                        owner_d = other_owner(owner_q);
                    end else begin
                        burst_inc = 1'b1;
                    end
                end else begin
                    burst_clr = 1'b1;
                end
                if (owner_d != owner_q) begin
                    burst_clr = 1'b1;
                    burst_inc = 1'b0;
                    last_d    = owner_q;
                end
            end
            default: begin
                owner_d   = OWN_IDLE;
                burst_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= OWN_IDLE;
            last_q  <= OWN_EXT;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Idle selects the core side so a parked core access needs no extra mux state.
    always_comb begin
        core_acc       = '0;
        core_acc.we    = bus.core_we_i;
        core_acc.addr  = DMEM_AW'(bus.core_addr_i);
        core_acc.wdata = DMEM_DW'(bus.core_wdata_i);
        ext_acc        = '0;
        ext_acc.we     = bus.ext_we_i;
        ext_acc.addr   = DMEM_AW'(bus.ext_addr_i);
        ext_acc.wdata  = DMEM_DW'(bus.ext_wdata_i);
        sel_acc        = (owner_q == OWN_EXT) ? ext_acc : core_acc;
    end

    assign bus.core_gnt_o   = core_gnt;
    assign bus.ext_gnt_o    = ext_gnt;
    assign bus.core_stall_o = bus.core_req_i & ~core_gnt;
    assign bus.core_rdata_o = bus.mem_rdata_i;
    assign bus.ext_rdata_o  = rst_i ? '0 : bus.mem_rdata_i;

    assign bus.mem_cs_o    = ~(core_gnt | ext_gnt);
    assign bus.mem_we_o    = (core_gnt | ext_gnt) & sel_acc.we;
    assign bus.mem_addr_o  = rst_i ? '0 : AW'(sel_acc.addr);
    assign bus.mem_wdata_o = rst_i ? '0 : DW'(sel_acc.wdata);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a cycle-level ownership model.
module tb_dmem_arbiter;

    localparam int unsigned DW        = 32;
    localparam int unsigned AW        = 32;
    localparam int unsigned MAX_BURST = 4;
`ifdef DMEM_ARB_PARK_CORE_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    dmem_arbiter #(
        .DW        (DW),
        .AW        (AW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Environment memory: 16 words, combinational read, written on the edge.
    logic [DW-1:0] env_mem [16];
    assign bus.mem_rdata_i = env_mem[bus.mem_addr_o[5:2]];

    function automatic logic [DW-1:0] word_init(input int i);
        return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + DW'(i * 17);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= word_init(i);
        end else if (!bus.mem_cs_o && bus.mem_we_o) begin
            env_mem[bus.mem_addr_o[5:2]] <= bus.mem_wdata_o;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: who holds the memory (0 none, 1 core, 2 ext), who held it last,
    // and how many grants the holder has taken while the other side was waiting.
    int            cur, prev, streak;
    logic [DW-1:0] ref_mem [16];
    bit            pred_cg, pred_eg, obs_cg, obs_eg;

    task automatic model_reset();
        cur    = 0;
        prev   = 2;
        streak = 0;
    endtask

    task automatic compare();
        bit cg, eg;
        cg = (cur == 1) && bus.core_req_i;
        eg = (cur == 2) && bus.ext_req_i;
        if (PARK && cur == 0 && bus.core_req_i && !bus.ext_req_i) cg = 1'b1;
        pred_cg = cg;
        pred_eg = eg;
        obs_cg  = bus.core_gnt_o;
        obs_eg  = bus.ext_gnt_o;
        check_eq("core_gnt", 64'(bus.core_gnt_o), 64'(cg));
        check_eq("ext_gnt", 64'(bus.ext_gnt_o), 64'(eg));
        check_eq("core_stall", 64'(bus.core_stall_o), 64'(bus.core_req_i && !cg));
        check_eq("mem_cs", 64'(bus.mem_cs_o), 64'(!(cg || eg)));
        check_eq("mem_we", 64'(bus.mem_we_o),
                 64'((cg && bus.core_we_i) || (eg && bus.ext_we_i)));
        if (cg || eg) begin
            check_eq("mem_addr", 64'(bus.mem_addr_o), 64'(cg ? bus.core_addr_i : bus.ext_addr_i));
        end
        if ((cg && bus.core_we_i) || (eg && bus.ext_we_i)) begin
            check_eq("mem_wdata", 64'(bus.mem_wdata_o),
                     64'(cg ? bus.core_wdata_i : bus.ext_wdata_i));
        end
        if (cg && !bus.core_we_i) begin
            check_eq("core_rdata", 64'(bus.core_rdata_o), 64'(ref_mem[bus.core_addr_i[5:2]]));
        end
        if (eg && !bus.ext_we_i) begin
            check_eq("ext_rdata", 64'(bus.ext_rdata_o), 64'(ref_mem[bus.ext_addr_i[5:2]]));
        end
    endtask

    task automatic advance();
        int nxt;
        bit c, e, own, oth;
        c = bus.core_req_i;
        e = bus.ext_req_i;
        if (pred_cg && bus.core_we_i) ref_mem[bus.core_addr_i[5:2]] = bus.core_wdata_i;
        if (pred_eg && bus.ext_we_i) ref_mem[bus.ext_addr_i[5:2]] = bus.ext_wdata_i;
        nxt = cur;
        if (cur == 0) begin
            if (c && e) nxt = (prev == 1) ? 2 : 1;
            else if (e) nxt = 2;
            else if (c && !PARK) nxt = 1;
        end else begin
            own = (cur == 1) ? c : e;
            oth = (cur == 1) ? e : c;
            if (!own) begin
                nxt = oth ? 3 - cur : 0;
            end else if (oth) begin
                streak++;
                if (streak == int'(MAX_BURST)) nxt = 3 - cur;
            end else begin
                streak = 0;
            end
        end
        if (nxt != cur) begin
            if (cur != 0) prev = cur;
            streak = 0;
            cur    = nxt;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic new_txn(input bit is_core);
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15)) << 2;
        if (is_core) begin
            bus.core_req_i   = 1'b1;
            bus.core_we_i    = 1'($urandom_range(0, 1));
            bus.core_addr_i  = a;
            bus.core_wdata_i = $urandom;
        end else begin
            bus.ext_req_i   = 1'b1;
            bus.ext_we_i    = 1'($urandom_range(0, 1));
            bus.ext_addr_i  = a;
            bus.ext_wdata_i = $urandom;
        end
    endtask

    task automatic idle_reqs();
        bus.core_req_i = 1'b0;
        bus.ext_req_i  = 1'b0;
    endtask

    // Requesters hold until granted; may withdraw while waiting.
    task automatic service(input int cycles, input int pct_new, input int pct_drop);
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (bus.core_req_i && obs_cg) begin
                if ($urandom_range(0, 99) < pct_new) new_txn(1'b1);
                else bus.core_req_i = 1'b0;
            end else if (bus.core_req_i) begin
                if ($urandom_range(0, 99) < pct_drop) bus.core_req_i = 1'b0;
            end else if ($urandom_range(0, 99) < pct_new) begin
                new_txn(1'b1);
            end
            if (bus.ext_req_i && obs_eg) begin
                if ($urandom_range(0, 99) < pct_new) new_txn(1'b0);
                else bus.ext_req_i = 1'b0;
            end else if (bus.ext_req_i) begin
                if ($urandom_range(0, 99) < pct_drop) bus.ext_req_i = 1'b0;
            end else if ($urandom_range(0, 99) < pct_new) begin
                new_txn(1'b0);
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_core_gnt", 64'(bus.core_gnt_o), 64'd0);
        check_eq("rst_ext_gnt", 64'(bus.ext_gnt_o), 64'd0);
        check_eq("rst_mem_we", 64'(bus.mem_we_o), 64'd0);
        check_eq("rst_mem_cs", 64'(bus.mem_cs_o), 64'd1);
        check_eq("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        check_eq("rst_mem_wdata", 64'(bus.mem_wdata_o), 64'd0);
        check_eq("rst_ext_rdata", 64'(bus.ext_rdata_o), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        model_reset();
        idle_reqs();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = word_init(i);
        model_reset();
        // Reset with both ports actively requesting writes.
        bus.core_req_i = 1'b1; bus.core_we_i = 1'b1;
        bus.core_addr_i = 32'h10; bus.core_wdata_i = 32'hFFFF_FFFF;
        bus.ext_req_i = 1'b1; bus.ext_we_i = 1'b1;
        bus.ext_addr_i = 32'h14; bus.ext_wdata_i = 32'hEEEE_EEEE;
        apply_reset();

        // Core load of the pre-seeded word.
        bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_addr_i = 32'h10;
        service(4, 0, 0);

        // Sustained contention: strict alternation in bursts of MAX_BURST, no idle gap.
        apply_reset();
        new_txn(1'b1);
        new_txn(1'b0);
        for (int k = 0; k < 13; k++) begin
            tick();
            check_eq("rr_core", 64'(obs_cg), 64'((k >= 1) && (((k - 1) / 4) % 2 == 0)));
            check_eq("rr_ext", 64'(obs_eg), 64'((k >= 1) && (((k - 1) / 4) % 2 == 1)));
            if (obs_cg) new_txn(1'b1);
            if (obs_eg) new_txn(1'b0);
        end
        idle_reqs();
        tick();

        // External write while the core waits, then the core reads it back.
        bus.ext_req_i = 1'b1; bus.ext_we_i = 1'b1;
        bus.ext_addr_i = 32'h20; bus.ext_wdata_i = 32'h1234;
        tick();
        bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_addr_i = 32'h20;
        service(6, 0, 0);
        check_eq("wr_then_rd", 64'(ref_mem[8]), 64'h1234);

        // External request withdrawn while the core owns the memory.
        bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_addr_i = 32'h0;
        tick();
        bus.ext_req_i = 1'b1; bus.ext_we_i = 1'b1;
        bus.ext_addr_i = 32'h24; bus.ext_wdata_i = 32'hBAD0_BAD0;
        tick();
        idle_reqs();
        tick();
        tick();

        // Asynchronous reset in the middle of an external write burst.
        bus.ext_req_i = 1'b1; bus.ext_we_i = 1'b1;
        bus.ext_addr_i = 32'h30; bus.ext_wdata_i = 32'h3030_3030;
        tick();
        tick();
        bus.ext_addr_i = 32'h34; bus.ext_wdata_i = 32'h3434_3434;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ext_gnt", 64'(bus.ext_gnt_o), 64'd0);
        check_eq("arst_mem_we", 64'(bus.mem_we_o), 64'd0);
        check_eq("arst_mem_cs", 64'(bus.mem_cs_o), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        new_txn(1'b1);
        new_txn(1'b0);
        tick();
        tick();
        check_eq("tie_after_rst", 64'(obs_cg), 64'd1);
        idle_reqs();
        tick();

        // Randomized traffic with occasional withdrawals.
        service(3000, 55, 6);
        idle_reqs();
        tick();

        for (int i = 0; i < 16; i++) check_eq("mem_final", 64'(env_mem[i]), 64'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
